glb_psum_writer: RTL

//  - Write-side master for the psum global buffer. Accepts X_dim-wide psum vectors from the PE array

---
 rtl/glb_psum_writer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/glb_psum_writer.sv
`default_nettype none
// ============================================================================
// Module   : glb_psum_writer
// Function : Serialises X_dim-wide psum vectors into the psum GLB single-element
//            write port at consecutive addresses from a programmed base.
//            Define GLB_PSUM_ACC_EN for read-accumulate-write operation.
// Revision : 1.0 - initial release
// ============================================================================
module glb_psum_writer #(
    parameter int DATA_BITWIDTH    = 16,
    parameter int ADDR_BITWIDTH    = 10,
    parameter int X_dim            = 3,
    parameter int VEC_CNT_BITWIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_BITWIDTH-1:0]       base_addr,
    input  logic [VEC_CNT_BITWIDTH-1:0]    num_vec,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_BITWIDTH*X_dim-1:0] in_data,
    output logic                           write_en,
    output logic [ADDR_BITWIDTH-1:0]       w_addr,
    output logic [DATA_BITWIDTH-1:0]       w_data,
    output logic                           read_req,
    output logic [ADDR_BITWIDTH-1:0]       r_addr,
    input  logic [DATA_BITWIDTH-1:0]       r_data
);

    localparam int                          c_ELEM_W    = (X_dim > 1) ? $clog2(X_dim) : 1;
    localparam logic [c_ELEM_W-1:0]         c_LAST_ELEM = c_ELEM_W'(X_dim - 1);
    localparam logic [VEC_CNT_BITWIDTH-1:0] c_ONE_VEC   = VEC_CNT_BITWIDTH'(1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RECV = 3'd1;
    localparam logic [2:0] c_WR   = 3'd2;
    localparam logic [2:0] c_DONE = 3'd3;
`ifdef GLB_PSUM_ACC_EN
    localparam logic [2:0] c_RD         = 3'd4;
    localparam logic [2:0] c_ELEM_START = c_RD;
`else
    localparam logic [2:0] c_ELEM_START = c_WR;
`endif

    logic [2:0]                       r_state;
    logic [ADDR_BITWIDTH-1:0]         r_addr_ptr;
    logic [VEC_CNT_BITWIDTH-1:0]      r_vec_left;
    logic [c_ELEM_W-1:0]              r_elem_cnt;
    logic [DATA_BITWIDTH*X_dim-1:0]   r_vec;

    // The captured vector is shifted down one element per write, so the
    // current element always sits in the low slice.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_addr_ptr <= '0;
            r_vec_left <= '0;
            r_elem_cnt <= '0;
            r_vec      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_addr_ptr <= base_addr;
                        r_vec_left <= num_vec;
                        r_state    <= (num_vec == '0) ? c_DONE : c_RECV;
                    end
                end
                c_RECV: begin
                    if (in_valid) begin
                        r_vec      <= in_data;
                        r_elem_cnt <= '0;
                        r_state    <= c_ELEM_START;
                    end
                end
`ifdef GLB_PSUM_ACC_EN
                c_RD: begin
                    r_state <= c_WR;
                end
`endif
                c_WR: begin
                    r_addr_ptr <= r_addr_ptr + 1'b1;
                    r_vec      <= r_vec >> DATA_BITWIDTH;
                    if (r_elem_cnt == c_LAST_ELEM) begin
                        r_elem_cnt <= '0;
                        if (r_vec_left == c_ONE_VEC) begin
                            r_state <= c_DONE;
                        end else begin
                            r_vec_left <= r_vec_left - 1'b1;
                            r_state    <= c_RECV;
                        end
                    end else begin
                        r_elem_cnt <= r_elem_cnt + 1'b1;
                        r_state    <= c_ELEM_START;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked during reset so an abandoned element never reaches the GLB.
    logic w_wr_state;
    assign w_wr_state = (r_state == c_WR) && !reset;

    assign busy     = (r_state != c_IDLE);
    assign done     = (r_state == c_DONE);
    assign in_ready = (r_state == c_RECV) && !reset;
    assign write_en = w_wr_state;
    assign w_addr   = w_wr_state ? r_addr_ptr : '0;

`ifdef GLB_PSUM_ACC_EN
    logic w_rd_state;
    assign w_rd_state = (r_state == c_RD) && !reset;
    assign read_req   = w_rd_state;
    assign r_addr     = w_rd_state ? r_addr_ptr : '0;
    assign w_data     = w_wr_state ? (r_vec[DATA_BITWIDTH-1:0] + r_data) : '0;
`else
    logic w_unused_r_data;
    assign w_unused_r_data = ^r_data;
    assign read_req        = 1'b0;
    assign r_addr          = '0;
    assign w_data          = w_wr_state ? r_vec[DATA_BITWIDTH-1:0] : '0;
`endif

endmodule
`default_nettype wire
